sysid_info_regs: RTL
====================

Name: sysid_info_regs

Overview:
- Parametrised successor to the single-word Avalon system-ID slave.
- Exposes a read-only identity block: SYSTEM_ID, build TIMESTAMP and VERSION.
- Adds a byte-writable scratch register, a 64-bit prescaled uptime counter with atomic hi/lo snapshot, and a control/status register.
- Sits on the Nios II data master as an Avalon-MM slave with fixed 1-cycle read latency.

Parameters:
- SYSTEM_ID, 32'h0, value returned at word 0.
- TIMESTAMP, 32'h0, build time (epoch seconds) returned at word 1.
- VERSION, 32'h0001_0000, {major[31:24], minor[23:16], patch[15:0]}, word 2.
- SCRATCH_RESET, 32'h0, reset value of the scratch register.
- PRESCALE, 1, clocks per uptime tick; legal range 1..65535.

Ports:
- clock  in  1  system clock, all logic rising-edge.
- reset_n  in  1  asynchronous active-low reset.
- address  in  3  word address.
- read  in  1  Avalon read strobe.
- write  in  1  Avalon write strobe.
- writedata  in  32  write data.
- byteenable  in  4  byte lanes for write.
- readdata  out  32  registered read data.
- readdatavalid  out  1  high one cycle after an accepted read.
- irq  out  1  overflow interrupt (see Optional Feature).

Behaviour:
- Reset: clock and reset are fixed. There is one clock, and reset is asynchronous and active-low (ports named clock and reset_n).
- Reset values:
  - readdata = 0, readdatavalid = 0, irq = 0.
  - scratch = SCRATCH_RESET.
  - uptime = 0, prescale counter = 0, snapshot = 0.
  - ctrl.run = 1, ctrl.irq_en = 0, status.ovf = 0.
- Reset mid-operation: asserting reset mid-transaction drops any pending readdatavalid immediately.
- Register map (word address):
  - 0 SYSTEM_ID, RO.
  - 1 TIMESTAMP, RO.
  - 2 VERSION, RO.
  - 3 SCRATCH, RW. Each byte is written only where its byteenable bit = 1.
  - 4 UPTIME_LO, RO. A read returns uptime[31:0] and, on the same edge, latches uptime[63:32] into the snapshot.
  - 5 UPTIME_HI, RO. Returns the snapshot, not the live upper word.
  - 6 CTRL:
    - bit0 run, RW.
    - bit1 clear, write-1 pulse; reads 0.
    - bit2 ovf, sticky; write-1-clears.
    - bit3 irq_en, RW.
    - Bits 31:4 read 0.
  - 7 reserved: reads 0, writes ignored.
- Writes to RO words are ignored with no side effect.
- Read timing: a read at edge N updates readdata and pulses readdatavalid at edge N+1. There are no wait states, and back-to-back reads are allowed every cycle.
- readdata holds its last value when readdatavalid = 0.
- Simultaneous read and write in one cycle: the write is performed and the read is dropped (readdatavalid stays 0).
- Prescaler:
  - When run = 1, the prescale counter counts 0..PRESCALE-1.
  - A tick is issued on the terminal count, then the counter wraps to 0.
  - PRESCALE = 1 gives a tick every cycle.
  - When run = 0, the prescaler and uptime freeze.
- Uptime:
  - Increments by 1 per tick.
  - On 64'hFFFF_FFFF_FFFF_FFFF + tick it wraps to 0 and sets ovf.
- Clear:
  - Writing CTRL with bit1 = 1 zeroes uptime, the prescale counter and the snapshot on that edge.
  - Clear overrides a coincident tick.
  - ovf is unaffected unless bit2 is also 1.
- Simultaneous set and clear of ovf (wrap on the same edge as a W1C write): set wins, so ovf = 1.
- Snapshot consistency: a UPTIME_LO read on the same edge as a carry from bit 31 latches the pre-increment hi and returns the pre-increment lo.

Optional Feature:
- Macro: SYSID_INFO_IRQ_EN.
- With the macro defined:
  - irq is a register, equal to ovf & irq_en, updated one cycle after either changes.
  - Clearing ovf deasserts irq on the next edge.
- Without the macro:
  - irq is tied to 0.
  - irq_en (CTRL bit3) is not implemented and reads 0; writes to it are ignored.
  - ovf still works as a polled status bit.

Test Plan:
- Identity read: after reset, reads at addresses 0, 1, 2, 7 with SYSTEM_ID = 32'h5894_4C48 → readdata 32'h5894_4C48, TIMESTAMP, VERSION, 0. Each result arrives with readdatavalid exactly 1 cycle after read.
- Scratch byte lanes: write 32'hDEAD_BEEF with byteenable = 4'b0101 over reset value 0 → read returns 32'h00AD_00EF. Then a write to address 0 is ignored; address 0 still returns SYSTEM_ID.
- Prescaled count: PRESCALE = 4, run for 40 clocks after reset → UPTIME_LO = 10 and UPTIME_HI = 0. Write run = 0, wait 20 clocks → value unchanged.
- Atomic snapshot: force uptime to 64'h0000_0001_FFFF_FFFF with PRESCALE = 1, then read LO on the carry edge → LO = 32'hFFFF_FFFF and the following HI read = 1, not 2.
- Overflow/IRQ (macro on): uptime = all-ones, irq_en = 1 → after one tick, uptime = 0, ovf = 1 and irq = 1 on the next edge. Write CTRL = 32'h0000_000D (W1C ovf) → irq = 0 next cycle. With the macro off, irq stays 0.
- Clear and collisions: write CTRL bit1 on a tick edge → uptime reads 0. Assert read and write together → no readdatavalid. Drop reset_n for 1 ns mid-read → readdatavalid = 0 and scratch = SCRATCH_RESET.

Source files
------------

// File: rtl/sysid_info_regs.sv
// System identity / scratch / uptime register block on an Avalon-MM slave, fixed 1-cycle read latency.
// Optional macro SYSID_INFO_IRQ_EN adds CTRL.irq_en and a registered overflow interrupt on irq.
module sysid_info_regs #(
  parameter logic [31:0] SYSTEM_ID     = 32'h0,
  parameter logic [31:0] TIMESTAMP     = 32'h0,
  parameter logic [31:0] VERSION       = 32'h0001_0000,
  parameter logic [31:0] SCRATCH_RESET = 32'h0,
  parameter int          PRESCALE      = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [2:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  output logic [31:0] readdata,
  output logic        readdatavalid,
  output logic        irq
);

  // Handshake: a read is accepted on every edge with read=1 and write=0 (no wait states);
  // readdatavalid pulses exactly one edge later with readdata, which otherwise holds.
  // A write in the same cycle wins and the read is dropped.
  localparam logic [15:0] PRESCALE_TC = 16'(PRESCALE - 1);

  localparam logic [2:0] A_SYSID   = 3'd0;
  localparam logic [2:0] A_STAMP   = 3'd1;
  localparam logic [2:0] A_VERSION = 3'd2;
  localparam logic [2:0] A_SCRATCH = 3'd3;
  localparam logic [2:0] A_UP_LO   = 3'd4;
  localparam logic [2:0] A_UP_HI   = 3'd5;
  localparam logic [2:0] A_CTRL    = 3'd6;

  logic [31:0] scratch;
  logic [15:0] presc_cnt;
  logic [63:0] uptime;
  logic [31:0] snap_hi;
  logic        run;
  logic        ovf;
  logic        irq_en;

  logic        rd_acc;
  logic        ctrl_wr;
  logic        clear;
  logic        ovf_w1c;
  logic        tick;
  logic        wrap;
  logic [31:0] rd_mux;

  assign rd_acc  = read & ~write;
  assign ctrl_wr = write && (address == A_CTRL);
  assign clear   = ctrl_wr & writedata[1];
  assign ovf_w1c = ctrl_wr & writedata[2];
  assign tick    = run && (presc_cnt == PRESCALE_TC);
  // A clear on the same edge swallows the tick, so it cannot wrap either.
  assign wrap    = tick & ~clear & (&uptime);

  always_comb begin
    rd_mux = 32'h0;
    case (address)
      A_SYSID:   rd_mux = SYSTEM_ID;
      A_STAMP:   rd_mux = TIMESTAMP;
      A_VERSION: rd_mux = VERSION;
      A_SCRATCH: rd_mux = scratch;
      A_UP_LO:   rd_mux = uptime[31:0];
      A_UP_HI:   rd_mux = snap_hi;
      A_CTRL:    rd_mux = {28'h0, irq_en, ovf, 1'b0, run};
      default:   rd_mux = 32'h0;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      readdata      <= 32'h0;
      readdatavalid <= 1'b0;
    end else begin
      readdatavalid <= rd_acc;
      if (rd_acc) readdata <= rd_mux;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      scratch <= SCRATCH_RESET;
    end else if (write && (address == A_SCRATCH)) begin
      for (int i = 0; i < 4; i++)
        if (byteenable[i]) scratch[i*8 +: 8] <= writedata[i*8 +: 8];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      presc_cnt <= 16'h0;
      uptime    <= 64'h0;
    end else if (clear) begin
      presc_cnt <= 16'h0;
      uptime    <= 64'h0;
    end else if (run) begin
      presc_cnt <= tick ? 16'h0 : presc_cnt + 16'h1;
      if (tick) uptime <= uptime + 64'h1;
    end
  end

  // Snapshot takes the pre-edge upper word, matching the pre-edge lower word returned.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                             snap_hi <= 32'h0;
    else if (clear)                           snap_hi <= 32'h0;
    else if (rd_acc && (address == A_UP_LO))  snap_hi <= uptime[63:32];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      run <= 1'b1;
      ovf <= 1'b0;
    end else begin
      if (ctrl_wr) run <= writedata[0];
      if (wrap)         ovf <= 1'b1;
      else if (ovf_w1c) ovf <= 1'b0;
    end
  end

`ifdef SYSID_INFO_IRQ_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      irq_en <= 1'b0;
      irq    <= 1'b0;
    end else begin
      if (ctrl_wr) irq_en <= writedata[3];
      irq <= ovf & irq_en;
    end
  end
`else
  assign irq_en = 1'b0;
  assign irq    = 1'b0;
`endif

endmodule
